alu_mult_sequencer: RTL and testbench

- Multi-cycle shift-add unsigned multiplier controller that reuses the shared WIDTH-bit ripple ALU as its adder.
- Owns the multiplicand and product registers and drives the ALU operand and control lines for WIDTH iterations.
- Sits beside the ALU in the datapath. Started by the top-level control on a MULT-class instruction; presents a 2*WIDTH product with a done pulse.

---
 rtl/alu_mult_sequencer_pkg.sv | 18 +
 rtl/alu_mult_step_counter.sv | 29 ++
 rtl/alu_mult_sequencer.sv | 112 +++++++++++
 tb/tb_alu_mult_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mult_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: ALU control
// codes driven onto alu_ctrl and the sequencer FSM state encoding.
package alu_mult_sequencer_pkg;

  // ALU control word layout: {ainvert, binvert, op[1:0]}
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mult_step_counter.sv
// Iteration counter for the multiplier: cleared when a multiply is
// accepted, advanced once per CALC cycle, flags the final iteration.
module mult_step_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign last = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_mult_sequencer.sv
// Shift-add unsigned multiplier controller. It owns the multiplicand and
// product registers and borrows the shared ripple ALU as its adder for
// WIDTH iterations, then pulses done with the 2*WIDTH-bit product.
//
// Handshake: start is a level request looked at only while IDLE; it is
// accepted on the clock edge where state is IDLE and start is high, and
// ignored (not queued) while busy, including the DONE cycle. done is a
// one-cycle pulse and product stays valid until the next accepted start.
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_ctrl,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout,
  output logic [1:0]         dbg_state
);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;
  logic               w_calc;
  logic [WIDTH-1:0]   r_multiplicand;
  logic [2*WIDTH-1:0] r_product;

  assign w_calc = (r_state == ST_CALC);

  mult_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_calc),
    .last  (w_last)
  );

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and start acceptance.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and one shift-add step per CALC cycle. The ALU sum is
  // WIDTH+1 bits wide so the carry lands in the product MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_multiplicand <= '0;
      r_product      <= '0;
    end else if (w_accept) begin
      r_multiplicand <= op_a;
      r_product      <= {{WIDTH{1'b0}}, op_b};
    end else if (w_calc) begin
      if (r_product[0]) begin
        r_product <= {alu_cout, alu_result, r_product[WIDTH-1:1]};
      end else begin
        r_product <= {1'b0, r_product[2*WIDTH-1:1]};
      end
    end
  end

  // ALU drive depends on registered state only, so start never reaches it.
  assign alu_a     = w_calc ? r_product[2*WIDTH-1:WIDTH] : '0;
  assign alu_b     = w_calc ? r_multiplicand : '0;
  assign alu_ctrl  = w_calc ? ALU_ADD : ALU_AND;
  assign alu_cin   = 1'b0;

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign product   = r_product;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: behavioural ALU on the alu_* ports and a
// plain arithmetic reference (64-bit multiply) for expected products.
module tb_alu_mult_sequencer;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    op_a, op_b;
  logic            busy, done;
  logic [2*W-1:0]  product;
  logic [W-1:0]    alu_a, alu_b, alu_result;
  logic [3:0]      alu_ctrl;
  logic            alu_cin, alu_cout;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  alu_mult_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .dbg_state  (dbg_state)
  );

  // behavioural ALU: AND / OR / ADD
  logic [W:0] w_sum;
  assign w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: begin
        alu_result = w_sum[W-1:0];
        alu_cout   = w_sum[W];
      end
      default: alu_result = '0;
    endcase
  end

  // driver: one multiply from an IDLE cycle, returns in the done cycle
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit scramble, output int lat,
                          output logic [2*W-1:0] prod, output bit cout_seen,
                          output int ctrl_bad);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; cout_seen = 1'b0; ctrl_bad = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (alu_ctrl !== 4'b0010 || alu_b !== a || busy !== 1'b1) ctrl_bad++;
      if (alu_cout === 1'b1 && product[0] === 1'b1) cout_seen = 1'b1;
      if (scramble) begin op_a = $urandom; op_b = $urandom; end
      @(posedge clk); #1;
      lat++;
    end
    if (done === 1'b1) done_cnt++;
    if (alu_ctrl !== 4'b0000 || alu_a !== '0 || alu_b !== '0) ctrl_bad++;
    prod = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL reset_product got %h exp 0", product); end
    checks++; if (alu_ctrl !== 4'b0000 || alu_a !== '0 || alu_b !== '0 || alu_cin !== 1'b0)
      begin errors++; $display("FAIL reset_alu ctrl=%b a=%h b=%h cin=%b exp 0000 0 0 0", alu_ctrl, alu_a, alu_b, alu_cin); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, cb; logic [2*W-1:0] p; bit cs;
    run_mult(32'd7, 32'd6, 1'b0, lat, p, cs, cb);
    checks++; if (lat != 33) begin errors++; $display("FAIL basic_latency got %0d exp 33", lat); end
    checks++; if (p !== 64'd42) begin errors++; $display("FAIL basic_product got %0d exp 42", p); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b exp 1", busy); end
    checks++; if (cb != 0) begin errors++; $display("FAIL basic_alu_drive bad_cycles %0d exp 0", cb); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_after busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (product !== 64'd42) begin errors++; $display("FAIL basic_hold got %0d exp 42", product); end
  endtask

  task automatic test_max();
    int lat, cb; logic [2*W-1:0] p; bit cs;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, p, cs, cb);
    checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_product got %h exp fffffffe00000001", p); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL max_cout_seen got %b exp 1", cs); end
    checks++; if (lat != 33 || cb != 0) begin errors++; $display("FAIL max_timing lat=%0d bad=%0d exp 33 0", lat, cb); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat, cb; logic [2*W-1:0] p; bit cs;
    run_mult(32'h1234_5678, 32'd0, 1'b0, lat, p, cs, cb);
    checks++; if (p !== '0 || lat != 33 || cb != 0) begin errors++; $display("FAIL zero_b p=%h lat=%0d bad=%0d exp 0 33 0", p, lat, cb); end
    @(posedge clk); #1;
    run_mult(32'd0, 32'hDEAD_BEEF, 1'b0, lat, p, cs, cb);
    checks++; if (p !== '0 || lat != 33 || cb != 0) begin errors++; $display("FAIL zero_a p=%h lat=%0d bad=%0d exp 0 33 0", p, lat, cb); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    start = 1'b1; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    op_a = 32'd9; op_b = 32'd9;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 33 || product !== 64'd15) begin errors++; $display("FAIL b2b_first lat=%0d p=%0d exp 33 15", lat, product); end
    if (done === 1'b1) done_cnt++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || product !== 64'd15) begin errors++; $display("FAIL b2b_idle busy=%b p=%0d exp 0 15", busy, product); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 33 || product !== 64'd81) begin errors++; $display("FAIL b2b_second lat=%0d p=%0d exp 33 81", lat, product); end
    if (done === 1'b1) done_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat, cb; logic [2*W-1:0] p; bit cs;
    start = 1'b1; op_a = 32'h1_0000; op_b = 32'h1_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrst_state st=%0d busy=%b done=%b exp 0 0 0", dbg_state, busy, done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL midrst_product got %h exp 0", product); end
    run_mult(32'd3, 32'd4, 1'b0, lat, p, cs, cb);
    checks++; if (p !== 64'd12 || lat != 33) begin errors++; $display("FAIL midrst_rerun p=%0d lat=%0d exp 12 33", p, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, cb, accepts, gap;
    logic [2*W-1:0] p, exp_p;
    logic [W-1:0] a, b;
    bit cs;
    accepts = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rand_gap busy=%b done=%b exp 0 0", busy, done); end
      end
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: a = '0;
        1: b = '1;
        2: a = '1;
        default: ;
      endcase
      exp_q.push_back({32'd0, a} * {32'd0, b});
      accepts++;
      run_mult(a, b, 1'b1, lat, p, cs, cb);
      exp_p = exp_q.pop_front();
      checks++; if (p !== exp_p || lat != 33 || cb != 0)
        begin errors++; $display("FAIL rand_%0d a=%h b=%h got %h exp %h lat=%0d bad=%0d", i, a, b, p, exp_p, lat, cb); end
      @(posedge clk); #1;
    end
    checks++; if (done_cnt != accepts) begin errors++; $display("FAIL rand_done_count got %0d exp %0d", done_cnt, accepts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
